apb_arbiter_2to1: RTL

//  Two-requester APB arbiter in front of one APB register block (e.g. io_base).

---
 rtl/apb_arbiter_2to1_if.sv | 27 ++
 rtl/apb_arbiter_2to1.sv | 126 ++++++++++++
 2 files changed

// File: rtl/apb_arbiter_2to1_if.sv
// APB signal bundle used for both requester ports and the downstream port.
// master drives request/attributes, slave drives the completion response.
interface apb_arbiter_2to1_if #(
  parameter int unsigned REGWIDTH     = 32,
  parameter int unsigned G_ADDR_WIDTH = 4
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [2:0]              pprot;
  logic [G_ADDR_WIDTH-1:0] paddr;
  logic [REGWIDTH-1:0]     pwdata;
  logic [REGWIDTH/8-1:0]   pstrb;
  logic                    pready;
  logic [REGWIDTH-1:0]     prdata;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, pprot, paddr, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, pprot, paddr, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_arbiter_2to1.sv
// Two-requester round-robin APB arbiter, one downstream transfer per grant.
// Optional ACCESS-phase timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_arbiter_2to1 #(
  parameter int unsigned REGWIDTH       = 32,
  parameter int unsigned G_ADDR_WIDTH   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  apb_arbiter_2to1_if.slave        s0_apb,
  apb_arbiter_2to1_if.slave        s1_apb,
  apb_arbiter_2to1_if.master       m_apb,
  output logic [1:0]               gnt
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e     state_q;
  logic [1:0] gnt_q;
  logic       ptr_q;
  logic       psel_q;
  logic       penable_q;

  logic       win1;
  logic       timeout_hit;
  logic       finish;
  logic [1:0] resp;

  // ptr_q holds the index last served; on a tie the other requester wins.
  assign win1   = (s0_apb.psel & s1_apb.psel) ? ~ptr_q : s1_apb.psel;
  assign finish = penable_q & (m_apb.pready | timeout_hit);

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CntW-1:0] cnt_q;

  assign timeout_hit = penable_q & ~m_apb.pready & (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      gnt_q     <= 2'b00;
      ptr_q     <= 1'b1;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (s0_apb.psel || s1_apb.psel) begin
            gnt_q   <= win1 ? 2'b10 : 2'b01;
            psel_q  <= 1'b1;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          penable_q <= 1'b1;
          state_q   <= StAccess;
        end
        StAccess: begin
          if (finish) begin
            ptr_q     <= gnt_q[1];
            gnt_q     <= 2'b00;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: begin
          gnt_q     <= 2'b00;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
`ifdef APB_ARB_TIMEOUT_EN
    // Counts ACCESS cycles without pready; cleared while in SETUP.
    if (!rst || state_q == StSetup) begin
      cnt_q <= '0;
    end else if (penable_q && !m_apb.pready && !timeout_hit) begin
      cnt_q <= cnt_q + 1'b1;
    end
`endif
  end

  assign m_apb.psel    = psel_q;
  assign m_apb.penable = penable_q;
  assign gnt           = gnt_q;

  always_comb begin
    m_apb.pwrite = 1'b0;
    m_apb.pprot  = '0;
    m_apb.paddr  = '0;
    m_apb.pwdata = '0;
    m_apb.pstrb  = '0;
    if (gnt_q[0]) begin
      m_apb.pwrite = s0_apb.pwrite;
      m_apb.pprot  = s0_apb.pprot;
      m_apb.paddr  = s0_apb.paddr;
      m_apb.pwdata = s0_apb.pwdata;
      m_apb.pstrb  = s0_apb.pstrb;
    end else if (gnt_q[1]) begin
      m_apb.pwrite = s1_apb.pwrite;
      m_apb.pprot  = s1_apb.pprot;
      m_apb.paddr  = s1_apb.paddr;
      m_apb.pwdata = s1_apb.pwdata;
      m_apb.pstrb  = s1_apb.pstrb;
    end
  end

  // A requester that dropped psel after its grant gets no response.
  assign resp[0] = finish & gnt_q[0] & s0_apb.psel;
  assign resp[1] = finish & gnt_q[1] & s1_apb.psel;

  assign s0_apb.pready  = resp[0];
  assign s0_apb.prdata  = (resp[0] & ~timeout_hit) ? m_apb.prdata : '0;
  assign s0_apb.pslverr = resp[0] & (timeout_hit | m_apb.pslverr);

  assign s1_apb.pready  = resp[1];
  assign s1_apb.prdata  = (resp[1] & ~timeout_hit) ? m_apb.prdata : '0;
  assign s1_apb.pslverr = resp[1] & (timeout_hit | m_apb.pslverr);

endmodule
